// File: rtl/reg_write_sequencer.sv
// Timed register-write sequencer: host commands are queued, then replayed as one-cycle bus strobes.
// Strobe appears two edges after a command enters an idle block; cmd_ready drops while the queue is full.

module rws_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_vld,
  output logic                   o_wr_rdy,
  input  logic [W-1:0]           i_wr_dat,
  input  logic                   i_rd_rdy,
  output logic                   o_rd_vld,
  output logic [W-1:0]           o_rd_dat,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  // Full blocks a push even when a pop happens on the same edge.
  assign o_wr_rdy = (r_level != LW'(DEPTH));
  assign o_rd_vld = (r_level != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];
  assign o_level  = r_level;
  assign w_push   = i_wr_vld && o_wr_rdy;
  assign w_pop    = i_rd_rdy && o_rd_vld;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module reg_write_sequencer #(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 1000,
  parameter int DELAY_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_addr,
  input  logic [4:0]             cmd_data,
  input  logic [DELAY_W-1:0]     cmd_delay,
  output logic                   write_strobe,
  output logic [2:0]             address,
  output logic [4:0]             data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef struct packed {
    logic [2:0]         addr;
    logic [4:0]         data;
    logic [DELAY_W-1:0] delay;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT} state_t;

  state_t                  r_state;
  cmd_t                    w_wr_dat;
  cmd_t                    w_head;
  logic                    w_head_vld;
  logic                    w_rd_rdy;
  logic                    w_pop;
  logic                    r_head_seen;
  logic [DELAY_W-1:0]      r_delay;
  logic [DELAY_W-1:0]      r_dcnt;
  logic [PRE_W-1:0]        r_pre;
  logic [$clog2(DEPTH):0]  w_level;

  assign w_wr_dat = {cmd_addr, cmd_data, cmd_delay};

  // A head entry is only taken once it has been visible for a full cycle,
  // which fixes the accept-to-strobe latency at two edges.
  assign w_rd_rdy = (r_state == S_IDLE) && r_head_seen;
  assign w_pop    = w_rd_rdy && w_head_vld;

  rws_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_wr_vld (cmd_valid),
    .o_wr_rdy (cmd_ready),
    .i_wr_dat (w_wr_dat),
    .i_rd_rdy (w_rd_rdy),
    .o_rd_vld (w_head_vld),
    .o_rd_dat (w_head),
    .o_level  (w_level)
  );

  assign fifo_level = w_level;
  assign busy       = (r_state != S_IDLE) || (w_level != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
      r_delay      <= '0;
      r_dcnt       <= '0;
      r_pre        <= '0;
      r_head_seen  <= 1'b0;
    end else begin
      r_head_seen  <= w_head_vld;
      write_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            address      <= w_head.addr;
            data         <= w_head.data;
            r_delay      <= w_head.delay;
            write_strobe <= 1'b1;
            r_state      <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_delay == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_dcnt  <= r_delay;
            r_pre   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Exit on the edge that completes the final tick: delay*TICK_DIV cycles in total.
          if (r_pre == PRE_LAST) begin
            r_pre  <= '0;
            r_dcnt <= r_dcnt - DELAY_W'(1);
            if (r_dcnt == DELAY_W'(1)) begin
              r_state <= S_IDLE;
            end
          end else begin
            r_pre <= r_pre + PRE_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_write_sequencer.sv
// Directed bench for reg_write_sequencer: timing-rule model checked every cycle plus literal spot checks.
module tb_reg_write_sequencer;
  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DELAY_W  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic [2:0]         cmd_addr = '0;
  logic [4:0]         cmd_data = '0;
  logic [DELAY_W-1:0] cmd_delay = '0;
  logic               cmd_ready;
  logic               write_strobe;
  logic [2:0]         address;
  logic [4:0]         data;
  logic               busy;
  logic [2:0]         fifo_level;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  reg_write_sequencer #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .DELAY_W  (DELAY_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_delay    (cmd_delay),
    .write_strobe (write_strobe),
    .address      (address),
    .data         (data),
    .busy         (busy),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_cnt, act, exp);
    end
  endtask

  // Model state: pending commands with their accept edge, plus timing horizons.
  int   q_acc[$];
  int   q_a[$];
  int   q_d[$];
  int   q_dl[$];
  int   free_edge  = 0;
  int   busy_until = -1;
  int   m_addr = 0;
  int   m_data = 0;
  bit   started = 1'b0;
  bit   c_rst = 1'b1;
  bit   c_vld = 1'b0;
  int   c_a = 0;
  int   c_d = 0;
  int   c_dl = 0;
  int   max_lvl = 0;
  int   obs_e[$];
  int   obs_a[$];
  int   obs_d[$];

  // Rules: a command strobes at max(accept+2, previous strobe + delay*TICK_DIV + 2);
  // the block is busy through the strobe cycle plus delay*TICK_DIV wait cycles.
  initial begin : model_and_compare
    int  e;
    bit  full;
    bit  m_stb;
    forever begin
      @(negedge clk);
      e     = edge_cnt;
      m_stb = 1'b0;
      if (c_rst) begin
        q_acc.delete(); q_a.delete(); q_d.delete(); q_dl.delete();
        free_edge  = 0;
        busy_until = -1;
        m_addr     = 0;
        m_data     = 0;
        started    = 1'b1;
      end else if (started) begin
        full = (q_acc.size() == DEPTH);
        if (q_acc.size() != 0 && e >= q_acc[0] + 2 && e >= free_edge) begin
          m_stb      = 1'b1;
          m_addr     = q_a[0];
          m_data     = q_d[0];
          busy_until = e + q_dl[0] * TICK_DIV;
          free_edge  = busy_until + 2;
          void'(q_acc.pop_front()); void'(q_a.pop_front());
          void'(q_d.pop_front());   void'(q_dl.pop_front());
        end
        if (c_vld && !full) begin
          q_acc.push_back(e); q_a.push_back(c_a);
          q_d.push_back(c_d); q_dl.push_back(c_dl);
        end
      end
      if (started) begin
        chk("strobe",  int'(write_strobe), int'(m_stb));
        chk("address", int'(address), m_addr);
        chk("data",    int'(data), m_data);
        chk("busy",    int'(busy), int'(q_acc.size() != 0 || e <= busy_until));
        chk("level",   int'(fifo_level), q_acc.size());
        chk("ready",   int'(cmd_ready), int'(q_acc.size() != DEPTH));
        if (write_strobe === 1'b1) begin
          obs_e.push_back(e);
          obs_a.push_back(int'(address));
          obs_d.push_back(int'(data));
        end
        if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      end
      c_rst = rst;
      c_vld = cmd_valid;
      c_a   = int'(cmd_addr);
      c_d   = int'(cmd_data);
      c_dl  = int'(cmd_delay);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int a, input int d, input int dl, output int acc);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_addr  = 3'(a);
    cmd_data  = 5'(d);
    cmd_delay = DELAY_W'(dl);
    while (!cmd_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!cmd_ready) chk("push_timeout", 0, 1);
    acc = edge_cnt + 1;
    tick(1);
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_addr  = 'x;
    cmd_data  = 'x;
    cmd_delay = 'x;
  endtask

  task automatic obs_clear();
    obs_e.delete(); obs_a.delete(); obs_d.delete();
  endtask

  initial begin : stimulus
    int a;
    int b;
    int n;
    int acc[6];

    // Reset and idle.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    idle_in();
    tick(50);
    chk("idle_strobes", obs_e.size(), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_level", int'(fifo_level), 0);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_addr", int'(address), 0);

    // Single write, delay 0.
    obs_clear();
    push(2, 9, 0, a);
    idle_in();
    tick(10);
    chk("single_count", obs_e.size(), 1);
    for (int i = 0; i < obs_e.size() && i < 1; i++) begin
      chk("single_latency", obs_e[i] - a, 2);
      chk("single_addr", obs_a[i], 2);
      chk("single_data", obs_d[i], 9);
    end

    // Timed spacing.
    obs_clear();
    push(0, 5, 3, a);
    push(1, 7, 0, b);
    idle_in();
    tick(30);
    chk("spacing_count", obs_e.size(), 2);
    if (obs_e.size() == 2) begin
      chk("spacing_gap", obs_e[1] - obs_e[0], 14);
      chk("spacing_a0", obs_a[0], 0);
      chk("spacing_d0", obs_d[0], 5);
      chk("spacing_a1", obs_a[1], 1);
      chk("spacing_d1", obs_d[1], 7);
    end

    // Full FIFO with cmd_valid held, six commands, delay 10.
    obs_clear();
    max_lvl = 0;
    for (int i = 0; i < 6; i++) push(i, 10 + i, 10, acc[i]);
    idle_in();
    tick(300);
    chk("full_max_level", max_lvl, 4);
    chk("full_sixth_accept", acc[5] - acc[0], 45);
    chk("full_count", obs_e.size(), 6);
    for (int i = 0; i < obs_e.size() && i < 6; i++) begin
      chk("full_order_data", obs_d[i], 10 + i);
      chk("full_order_addr", obs_a[i], i);
      if (i > 0) chk("full_gap", obs_e[i] - obs_e[i-1], 42);
    end

    // Reset during WAIT.
    obs_clear();
    push(3, 1, 5, a);
    idle_in();
    n = 0;
    while (obs_e.size() == 0 && n < 20) begin
      tick(1);
      n++;
    end
    chk("midwait_strobe_seen", obs_e.size(), 1);
    if (obs_e.size() == 1) begin
      n = obs_e[0] + 5 - edge_cnt;
      if (n > 0) tick(n);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(40);
    chk("midwait_no_more", obs_e.size(), 1);
    chk("midwait_busy", int'(busy), 0);
    chk("midwait_level", int'(fifo_level), 0);
    obs_clear();
    push(4, 2, 0, a);
    idle_in();
    tick(6);
    chk("after_rst_count", obs_e.size(), 1);
    for (int i = 0; i < obs_e.size() && i < 1; i++) begin
      chk("after_rst_latency", obs_e[i] - a, 2);
      chk("after_rst_addr", obs_a[i], 4);
      chk("after_rst_data", obs_d[i], 2);
    end

    // Back-to-back delay 0.
    obs_clear();
    for (int i = 0; i < 4; i++) push(5, 20 + i, 0, acc[i]);
    idle_in();
    tick(12);
    chk("b2b_count", obs_e.size(), 4);
    for (int i = 0; i < obs_e.size() && i < 4; i++) begin
      chk("b2b_data", obs_d[i], 20 + i);
      if (i == 0) chk("b2b_latency", obs_e[0] - acc[0], 2);
      else chk("b2b_gap", obs_e[i] - obs_e[i-1], 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_write_sequencer.md
Name: reg_write_sequencer

Overview:
Master-side driver for the signal generator's register-write bus (write_strobe / address[2:0] / data[4:0]). It accepts timed register-write commands from a host over a valid/ready interface and buffers them in a small FIFO. It replays each command as a single-cycle write strobe, then holds off for a programmable number of timebase ticks. Typical use is note/envelope playback without host timing.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
TICK_DIV, 1000, clock cycles per delay tick; >= 1
DELAY_W, 8, width of per-command delay field

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  host command valid
cmd_ready  output  1  FIFO can accept a command
cmd_addr  input  3  target register address
cmd_data  input  5  register write data
cmd_delay  input  DELAY_W  ticks to wait after this write
write_strobe  output  1  one-cycle register write pulse
address  output  3  register address to generator
data  output  5  register data to generator
busy  output  1  FIFO non-empty or FSM not IDLE
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates on posedge clk.
- Reset (rst high at an edge):
  - FIFO flushed; fifo_level=0; cmd_ready=1.
  - State=IDLE; write_strobe=0; address=0; data=0; busy=0.
  - Prescaler and delay counter cleared.
  - Applies mid-WAIT or mid-WRITE as well: the pending command is discarded and no strobe is issued after reset.
- FIFO:
  - Push when cmd_valid && cmd_ready at an edge.
  - cmd_ready = (fifo_level != DEPTH), combinational from registered level.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, WRITE, WAIT:
  - IDLE: if FIFO non-empty, pop the head into holding registers {addr, data, delay} and go to WRITE; otherwise stay.
  - WRITE (exactly 1 cycle):
    - write_strobe=1, address/data = held values.
    - If delay==0, go to IDLE; else load delay counter, clear prescaler, go to WAIT.
  - WAIT: prescaler counts 0..TICK_DIV-1; on wrap, decrement delay counter. Leave to IDLE on the cycle the last tick completes. WAIT lasts exactly delay*TICK_DIV cycles.
- Outputs:
  - write_strobe is registered and high only in WRITE.
  - address and data hold their last written values between strobes.
- Latency:
  - Command accepted at edge N into an empty, IDLE block gives write_strobe high in the cycle after edge N+2.
  - Strobe-to-strobe spacing for queued commands = delay*TICK_DIV + 2 cycles. Minimum spacing is 2 cycles at delay=0.
- busy = (state != IDLE) || (fifo_level != 0).
- Widths: prescaler $clog2(TICK_DIV) bits (min 1); delay counter DELAY_W bits. No overflow possible; delay = 2^DELAY_W - 1 is legal.
- cmd_* inputs are ignored when not handshaken; X on cmd_* while cmd_valid=0 has no effect.

Test Plan:
- Reset/idle: rst for 2 cycles, no commands -> write_strobe=0, address=0, data=0, busy=0, cmd_ready=1, fifo_level=0 for 50 cycles.
- Single write, TICK_DIV=4: push {addr=2, data=9, delay=0} at edge N -> exactly one strobe in cycle N+2 with address=2, data=9; busy returns to 0 the following cycle.
- Timed spacing, TICK_DIV=4: push {0,5,3} then {1,7,0} -> strobes exactly 3*4+2=14 cycles apart, carrying (0,5) then (1,7).
- Full FIFO, DEPTH=4, TICK_DIV=4: push 6 commands back-to-back with delay=10 and cmd_valid held high:
  - cmd_ready drops when fifo_level=4.
  - Every command is accepted exactly once, none lost or duplicated.
  - Strobes occur in push order.
  - Pointers wrap correctly.
- Reset mid-WAIT: push {3,1,5}, assert rst 6 cycles after the strobe -> no further strobes, FIFO empty, busy=0. A subsequent push {4,2,0} strobes after the nominal 2-cycle latency.
- Back-to-back delay=0: push 4 commands with delay=0 -> strobes every 2 cycles with data sequence matching push order; busy held high throughout.
